writeback_stage: RTL and testbench

//  Clocked writeback stage directly downstream of the asynchronous ALU.
//  - Synchronises ALU readyOut, captures its results, commits them to the 16x32 register file and CPSR.
//  - Returns the two-phase (toggle) trigger that releases the ALU for its next operation.
//  - Provides decoder read ports, a PC-redirect pulse and a retired-instruction counter.

---
 rtl/writeback_stage.sv | 179 +++++++++++++++++
 tb/tb_writeback_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   Clocked writeback stage sitting directly behind the asynchronous ALU.
//   Synchronises the ALU readyOut level, captures the ALU results on its rising
//   edge, commits them to a 16-entry register file and the CPSR flags, then
//   toggles triggerOut (two-phase handshake) to release the ALU.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : during COMMIT a read port addressing a register being written
//                 this cycle returns the new value (Rd beats Rn on a tie).
//     undefined : reads return pre-commit contents until the following cycle.
//
// Ports
//   clk, resetN            clock (rising edge), synchronous active-low reset
//   dataIn1 / dataIn2      ALU result for Rd / base-writeback value for Rn
//   cpsrIn                 ALU flags in [31:28]
//   wIn                    Rd write enable
//   srcDstIn               [3:0] Rd, [7:4] Rn, [8] S (update flags), [9] Rn writeback
//   readyIn                ALU readyOut, asynchronous level
//   triggerOut             toggle to ALU triggerIn; each edge = result consumed
//   rdAddrA/B, rdDataA/B   combinational decoder read ports
//   cpsr                   architectural CPSR
//   pcWe, pcOut            one-cycle pulse + value when r15 was written
//   retireCount            committed instruction count (wraps)
//   busy                   high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit KICK_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] cpsrIn,
    input  logic              wIn,
    input  logic [31:0]       srcDstIn,
    input  logic              readyIn,
    output logic              triggerOut,
    input  logic [3:0]        rdAddrA,
    output logic [DATA_W-1:0] rdDataA,
    input  logic [3:0]        rdAddrB,
    output logic [DATA_W-1:0] rdDataB,
    output logic [DATA_W-1:0] cpsr,
    output logic              pcWe,
    output logic [DATA_W-1:0] pcOut,
    output logic [31:0]       retireCount,
    output logic              busy
);

    typedef enum logic [2:0] {
        KICK   = 3'd0,
        IDLE   = 3'd1,
        COMMIT = 3'd2,
        ACK    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    localparam state_t RST_STATE = KICK_ON_RST ? KICK : IDLE;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_sync, rdy_prev, rdy_rise;

    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] d1_q, d2_q;
    logic [3:0]        cpsr_flags_q;
    logic              w_q, s_q, wb_q;
    logic [3:0]        rd_q, rn_q;
    logic [31:0]       retire_cnt;

    logic              capture, commit, trig_toggle;
    logic              wr_rd, wr_rn, pc_hit;
    logic [DATA_W-1:0] pc_val;

    // Only the Rd/Rn/S/W fields of srcDstIn and the flag nibble of cpsrIn matter.
    logic unused_inputs;
    assign unused_inputs = ^{srcDstIn[31:10], cpsrIn[27:0]};

    assign rdy_sync = sync_q[SYNC_STAGES-1];
    assign rdy_rise = rdy_sync & ~rdy_prev;

    assign capture     = (state_q == IDLE) && rdy_rise;
    assign commit      = (state_q == COMMIT);
    assign trig_toggle = (state_q == KICK) || (state_q == ACK);

    assign wr_rd  = commit && w_q;
    assign wr_rn  = commit && wb_q;
    // Rd port wins for r15 as it does for the register file itself.
    assign pc_hit = (wr_rd && rd_q == 4'd15) || (wr_rn && rn_q == 4'd15);
    assign pc_val = (wr_rd && rd_q == 4'd15) ? d1_q : d2_q;

    assign busy        = (state_q != IDLE);
    assign retireCount = retire_cnt;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            KICK:    state_d = DRAIN;
            IDLE:    if (rdy_rise) state_d = COMMIT;
            COMMIT:  state_d = ACK;
            ACK:     state_d = DRAIN;
            DRAIN:   if (!rdy_sync) state_d = IDLE;
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= RST_STATE;
            sync_q       <= '0;
            rdy_prev     <= 1'b0;
            triggerOut   <= 1'b0;
            pcWe         <= 1'b0;
            pcOut        <= '0;
            cpsr         <= '0;
            retire_cnt   <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            cpsr_flags_q <= '0;
            w_q          <= 1'b0;
            s_q          <= 1'b0;
            wb_q         <= 1'b0;
            rd_q         <= '0;
            rn_q         <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], readyIn};
            rdy_prev <= rdy_sync;
            pcWe     <= 1'b0;

            if (trig_toggle) triggerOut <= ~triggerOut;

            if (capture) begin
                d1_q         <= dataIn1;
                d2_q         <= dataIn2;
                cpsr_flags_q <= cpsrIn[31:28];
                w_q          <= wIn;
                rd_q         <= srcDstIn[3:0];
                rn_q         <= srcDstIn[7:4];
                s_q          <= srcDstIn[8];
                wb_q         <= srcDstIn[9];
            end

            // Rd is written last so it wins when Rn == Rd.
            if (wr_rn) regs[rn_q] <= d2_q;
            if (wr_rd) regs[rd_q] <= d1_q;

            if (commit) begin
                if (s_q) cpsr[31:28] <= cpsr_flags_q;
                retire_cnt <= retire_cnt + 32'd1;
                pcWe       <= pc_hit;
                if (pc_hit) pcOut <= pc_val;
            end
        end
    end

`ifdef WB_BYPASS_EN
    function automatic logic [DATA_W-1:0] rd_port(input logic [3:0] addr,
                                                 input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] v;
        v = stored;
        if (wr_rn && rn_q == addr) v = d2_q;
        if (wr_rd && rd_q == addr) v = d1_q;
        return v;
    endfunction

    assign rdDataA = rd_port(rdAddrA, regs[rdAddrA]);
    assign rdDataB = rd_port(rdAddrB, regs[rdAddrB]);
`else
    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] dataIn1, dataIn2, cpsrIn, srcDstIn;
    logic        wIn, readyIn;
    logic        triggerOut;
    logic [3:0]  rdAddrA, rdAddrB;
    logic [31:0] rdDataA, rdDataB, cpsr, pcOut, retireCount;
    logic        pcWe, busy;

    writeback_stage #(.DATA_W(32), .SYNC_STAGES(SYNC), .KICK_ON_RST(1'b1)) dut (
        .clk(clk), .resetN(resetN),
        .dataIn1(dataIn1), .dataIn2(dataIn2), .cpsrIn(cpsrIn), .wIn(wIn),
        .srcDstIn(srcDstIn), .readyIn(readyIn), .triggerOut(triggerOut),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .cpsr(cpsr), .pcWe(pcWe), .pcOut(pcOut), .retireCount(retireCount), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference state: architectural view only.
    logic [31:0] m_regs [16];
    logic [31:0] m_cpsr, m_cnt;
    int          n_chk = 0, n_pass = 0;

    // pcWe monitor: counts high cycles and remembers the value shown with it.
    int          pc_total = 0;
    logic [31:0] pc_val = '0;
    always @(negedge clk) if (pcWe === 1'b1) begin
        pc_total <= pc_total + 1;
        pc_val   <= pcOut;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_cpsr = '0;
        m_cnt  = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            rdAddrA = i[3:0];
            #1;
            chk(tag, rdDataA, m_regs[i]);
        end
    endtask

    // One ALU result: present data, raise readyIn, wait for the trigger edge.
    task automatic xact(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] ci,
                        input logic w, input logic [31:0] sd,
                        input logic [3:0] aa, input logic [3:0] ab);
        logic [31:0] old_a, new_a, exp_pc;
        logic        exp_pcwe, trig0;
        logic [3:0]  rd, rn;
        int          cyc, pc0;
        rd = sd[3:0];
        rn = sd[7:4];
        @(negedge clk);
        dataIn1 = d1; dataIn2 = d2; cpsrIn = ci; wIn = w; srcDstIn = sd;
        rdAddrA = aa; rdAddrB = ab;

        old_a = m_regs[aa];
        new_a = old_a;
        if (sd[9] && rn == aa) new_a = d2;
        if (w && rd == aa)     new_a = d1;
        exp_pcwe = (w && rd == 4'd15) || (sd[9] && rn == 4'd15);
        exp_pc   = (w && rd == 4'd15) ? d1 : d2;
        if (sd[9]) m_regs[rn] = d2;
        if (w)     m_regs[rd] = d1;
        if (sd[8]) m_cpsr[31:28] = ci[31:28];
        m_cnt = m_cnt + 1;

        pc0   = pc_total;
        trig0 = triggerOut;
        readyIn = 1'b1;
        cyc = 0;
        while (triggerOut === trig0 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == SYNC + 1) begin
`ifdef WB_BYPASS_EN
                chk("commit_rdA", rdDataA, new_a);
`else
                chk("commit_rdA", rdDataA, old_a);
`endif
            end
        end
        readyIn = 1'b0;
        chk("latency", cyc, SYNC + 3);
        chk("pcwe_cycles", pc_total - pc0, exp_pcwe ? 1 : 0);
        if (exp_pcwe) chk("pcout", pc_val, exp_pc);
        chk("rdA", rdDataA, m_regs[aa]);
        chk("rdB", rdDataB, m_regs[ab]);
        chk("cpsr", cpsr, m_cpsr);
        chk("retire", retireCount, m_cnt);
        wait_idle("drain_idle");
    endtask

    initial begin
        int cyc;
        logic [31:0] sd;
        resetN = 1'b0; readyIn = 1'b0; wIn = 1'b0;
        dataIn1 = '0; dataIn2 = '0; cpsrIn = '0; srcDstIn = '0;
        rdAddrA = '0; rdAddrB = '0;
        model_reset();

        // 1: reset state, then single kick toggle and settle in IDLE
        repeat (3) @(negedge clk);
        chk("rst_trig", {31'd0, triggerOut}, 32'd0);
        chk("rst_pcwe", {31'd0, pcWe}, 32'd0);
        chk("rst_pcout", pcOut, 32'd0);
        chk("rst_cpsr", cpsr, 32'd0);
        chk("rst_retire", retireCount, 32'd0);
        chk("rst_busy_kick", {31'd0, busy}, 32'd1);
        resetN = 1'b1;
        @(negedge clk);
        chk("kick_trig", {31'd0, triggerOut}, 32'd1);
        wait_idle("kick_idle");
        repeat (4) @(negedge clk);
        chk("kick_once", {31'd0, triggerOut}, 32'd1);
        check_all_regs("rst_regs");

        // 2: plain Rd write
        xact(32'h1234_5678, 32'h0, 32'hF000_0000, 1'b1, 32'h003, 4'd3, 4'd0);
        // 3: flags only, no register written
        xact(32'hDEAD_BEEF, 32'h0, 32'h6000_0000, 1'b0, 32'h104, 4'd4, 4'd3);
        // 4: r15 write -> pcWe pulse
        xact(32'h0000_0100, 32'h0, 32'h0, 1'b1, 32'h00F, 4'd15, 4'd15);
        // 5: Rd == Rn, Rd wins; port A watches reg2 during COMMIT
        xact(32'h0000_000A, 32'h0000_000B, 32'h0, 1'b1, 32'h222, 4'd2, 4'd2);
        // Rn-only writeback into r15
        xact(32'h0, 32'h0000_0200, 32'h0, 1'b0, 32'h2F1, 4'd15, 4'd1);
        // no-effect result still retires
        xact(32'h5555_5555, 32'h6666_6666, 32'hA000_0000, 1'b0, 32'h0, 4'd0, 4'd5);

        // randomized results
        for (int t = 0; t < 40; t++) begin
            sd = {22'd0, $urandom_range(0, 3) == 0 ? 2'b00 : 2'($urandom), 8'($urandom)};
            xact($urandom, $urandom, $urandom, 1'($urandom), sd,
                 4'($urandom), 4'($urandom));
        end
        check_all_regs("rand_regs");

        // 6a: retire counter wrap
        @(negedge clk);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_cnt;
        @(negedge clk);
        m_cnt = 32'hFFFF_FFFF;
        chk("preload", retireCount, 32'hFFFF_FFFF);
        xact(32'h0000_0077, 32'h0, 32'h0, 1'b1, 32'h007, 4'd7, 4'd7);
        chk("wrap_zero", retireCount, 32'd0);

        // 6b: reset while in COMMIT discards the captured result
        @(negedge clk);
        dataIn1 = 32'hCAFE_F00D; wIn = 1'b1; srcDstIn = 32'h005; rdAddrA = 4'd5;
        readyIn = 1'b1;
        repeat (SYNC + 1) begin
            @(posedge clk);
            @(negedge clk);
        end
        resetN = 1'b0;
        @(negedge clk);
        model_reset();
        chk("rstc_trig", {31'd0, triggerOut}, 32'd0);
        chk("rstc_reg5", rdDataA, 32'd0);
        chk("rstc_retire", retireCount, 32'd0);
        readyIn = 1'b0;
        resetN = 1'b1;
        @(negedge clk);
        chk("rstc_kick", {31'd0, triggerOut}, 32'd1);
        wait_idle("rstc_idle");
        check_all_regs("rstc_regs");
        xact(32'h0000_0042, 32'h0, 32'h8000_0000, 1'b1, 32'h109, 4'd9, 4'd9);

        cyc = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
